data_mem_responder: RTL

//  Byte-wide data-memory responder for the memory stage's serial write and read

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-wide data-memory responder with wait states
//
// Serves one request at a time from the memory stage's serial sequencers. It
// captures the request, waits WAIT cycles, then commits the write or returns
// the read data alongside a one-cycle ack. Addresses at or above DEPTH are
// flagged with err and never touch the array.
//
// Optional feature: define DMEM_RESET_CLEAR_EN to zero the whole array after
// every reset release. While it clears, busy=1 and req is ignored.
//
// Ports:
//   i_clk    clock; all state updates on its rising edge
//   i_rst    reset, asynchronous, active-low
//   i_req    request valid; sampled only while idle
//   i_we     1 = write, 0 = read; captured with i_req
//   i_addr   byte address; captured with i_req
//   i_wdata  write data; captured with i_req
//   o_ack    one-cycle acknowledge per accepted request
//   o_rdata  read data; valid only while o_ack=1, 0 otherwise
//   o_err    high with o_ack when the captured address is >= DEPTH
//   o_busy   high whenever the responder is not idle
module data_mem_responder #(
   parameter int L     = 8,
   parameter int A     = 6,
   parameter int DEPTH = 64,
   parameter int WAIT  = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_req,
   input  logic         i_we,
   input  logic [A-1:0] i_addr,
   input  logic [L-1:0] i_wdata,
   output logic         o_ack,
   output logic [L-1:0] o_rdata,
   output logic         o_err,
   output logic         o_busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   localparam logic [A:0] DEPTH_W = (A+1)'(DEPTH);
   localparam logic [3:0] WAIT_L  = 4'(WAIT);

   logic [1:0]   r_state;
   logic [3:0]   r_cnt;
   logic         r_we;
   logic [A-1:0] r_addr;
   logic [L-1:0] r_wdata;
   logic         r_ack;
   logic         r_err;
   logic [L-1:0] r_rdata;
   logic [L-1:0] r_mem [DEPTH];

`ifdef DMEM_RESET_CLEAR_EN
   logic         r_clr_pend;
   logic [A-1:0] r_clr_ptr;
`endif

   logic         w_in_range;
   logic         w_commit;
   logic         w_mem_we;
   logic [A-1:0] w_mem_addr;
   logic [L-1:0] w_mem_din;

   assign w_in_range = {1'b0, r_addr} < DEPTH_W;
   // The counter starts at WAIT and the response edge is the one where it
   // reads zero, so capture-to-ack is always WAIT+1 edges (one even for WAIT=0).
   assign w_commit   = (r_state == S_WAIT) && (r_cnt == 4'd0);

   // Single write port shared by request commits and the post-reset clear.
   always_comb begin
      w_mem_we   = w_commit && r_we && w_in_range;
      w_mem_addr = r_addr;
      w_mem_din  = r_wdata;
`ifdef DMEM_RESET_CLEAR_EN
      if (r_state == S_CLEAR) begin
         w_mem_we   = 1'b1;
         w_mem_addr = r_clr_ptr;
         w_mem_din  = '0;
      end
`endif
   end

   // The array has no reset: contents survive rst unless the clear is built in.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_din;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
`ifdef DMEM_RESET_CLEAR_EN
         r_clr_pend <= 1'b1;
         r_clr_ptr  <= '0;
`endif
      end else begin
         // Response outputs are single-cycle pulses unless re-set below.
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         case (r_state)
            S_IDLE: begin
`ifdef DMEM_RESET_CLEAR_EN
               if (r_clr_pend) begin
                  r_clr_pend <= 1'b0;
                  r_clr_ptr  <= '0;
                  r_state    <= S_CLEAR;
               end else
`endif
               if (i_req) begin
                  r_we    <= i_we;
                  r_addr  <= i_addr;
                  r_wdata <= i_wdata;
                  r_cnt   <= WAIT_L;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_ack   <= 1'b1;
                  r_err   <= ~w_in_range;
                  r_rdata <= (!r_we && w_in_range) ? r_mem[r_addr] : '0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
`ifdef DMEM_RESET_CLEAR_EN
            S_CLEAR: begin
               r_clr_ptr <= r_clr_ptr + 1'b1;
               if ({1'b0, r_clr_ptr} == DEPTH_W - (A+1)'(1)) begin
                  r_state <= S_IDLE;
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_ack   = r_ack;
   assign o_err   = r_err;
   assign o_rdata = r_rdata;
   assign o_busy  = (r_state != S_IDLE);

endmodule
